// File: rtl/serial_addsub_unit.sv
// rtl/serial_addsub_unit.sv - digit-serial signed adder/subtractor with start/done handshake
// Optional macro SATURATE_EN clamps Sum on signed overflow.
module serial_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_addsub_unit: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d, busy_q, busy_d, done_q, done_d;
  logic               carry_q, carry_d, ovf_q, ovf_d;

  logic [DIGIT:0]     dig_sum;
  logic               msb_cin;
  logic [WIDTH-1:0]   acc_shift;

  always_comb begin
    dig_sum   = ({1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}) + {{DIGIT{1'b0}}, cy_q};
    // Carry into the digit MSB recovered from the sum bit and the two operand bits.
    msb_cin   = dig_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = dig_sum[DIGIT];
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = acc_shift;
          carry_d = dig_sum[DIGIT];
          ovf_d   = dig_sum[DIGIT] ^ msb_cin;
`ifdef SATURATE_EN
          // a_q now holds the top digit of A, whose MSB is the sign of the true result.
          if (dig_sum[DIGIT] ^ msb_cin) begin
            sum_d = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B ^ {WIDTH{Opcode}};
          cy_d    = Opcode;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Sum      = sum_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb/tb_serial_addsub_unit.sv - directed self-checking bench for serial_addsub_unit
module tb_serial_addsub_unit;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, op8 = 0, busy8, done8, c8, v8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic        start16 = 0, op16 = 0, busy16, done16, c16, v16;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  logic       start1 = 0, op1 = 0, busy1, done1, c1, v1;
  logic [7:0] a1 = 0, b1 = 0, sum1;

  serial_addsub_unit #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .Opcode(op8),
    .busy(busy8), .done(done8), .Sum(sum8), .Carry(c8), .Overflow(v8));

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16), .Opcode(op16),
    .busy(busy16), .done(done16), .Sum(sum16), .Carry(c16), .Overflow(v16));

  serial_addsub_unit #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1), .Opcode(op1),
    .busy(busy1), .done(done1), .Sum(sum1), .Carry(c1), .Overflow(v1));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic op,
                      input logic [7:0] es, input logic ec, input logic ev);
    int lat;
    a8 = a; b8 = b; op8 = op; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; op8 = ~op;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_carry"}, 32'(c8), 32'(ec));
    chk({tag, "_ovf"}, 32'(v8), 32'(ev));
    chk({tag, "_busy_done"}, 32'(busy8), 32'd0);
  endtask

  task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b, input logic op,
                      input logic [7:0] es, input logic ec, input logic ev);
    a1 = a; b1 = b; op1 = op; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    chk({tag, "_busy"}, 32'(busy1), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'(done1), 32'd1);
    chk({tag, "_sum"}, 32'(sum1), 32'(es));
    chk({tag, "_carry"}, 32'(c1), 32'(ec));
    chk({tag, "_ovf"}, 32'(v1), 32'(ev));
  endtask

  initial begin
    int ndone;
    int dlat;
    logic [7:0] dsum;
    logic dovf;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_carry", 32'(c8), 32'd0);
    chk("rst_ovf", 32'(v8), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run8("t1", 8'd100, 8'd100, 1'b0, SAT ? 8'h7F : 8'hC8, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_hold_sum", 32'(sum8), 32'(SAT ? 8'h7F : 8'hC8));
    chk("t1_hold_done", 32'(done8), 32'd0);

    run8("t2a", 8'd50, 8'd60, 1'b1, 8'hF6, 1'b0, 1'b0);
    run8("t2b", 8'hF6, 8'hF4, 1'b0, 8'hEA, 1'b1, 1'b0);
    @(posedge clk); #1;

    run8("t3", 8'h85, 8'd6, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Second start pulse lands while the first op is still running.
    a8 = 8'd127; b8 = 8'd120; op8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
    ndone = 0; dlat = 0; dsum = 8'h00; dovf = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) start8 = 1'b1;
      if (c == 3) start8 = 1'b0;
      if (done8) begin
        ndone++; dlat = c; dsum = sum8; dovf = v8;
      end
    end
    chk("t4_ndone", 32'(ndone), 32'd1);
    chk("t4_lat", 32'(dlat), 32'd4);
    chk("t4_sum", 32'(dsum), 32'(SAT ? 8'h7F : 8'hF7));
    chk("t4_ovf", 32'(dovf), 32'd1);

    a8 = 8'd5; b8 = 8'd6; op8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_busy", 32'(busy8), 32'd0);
    chk("t5_sum", 32'(sum8), 32'd0);
    chk("t5_carry", 32'(c8), 32'd0);
    chk("t5_ovf", 32'(v8), 32'd0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done8) ndone++;
      @(posedge clk); #1;
    end
    chk("t5_nodone", 32'(ndone), 32'd0);
    run8("t5r", 8'd5, 8'd6, 1'b0, 8'd11, 1'b0, 1'b0);

    a16 = 16'h8000; b16 = 16'd1; op16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321;
    dlat = 0;
    while (!done16 && dlat < 20) begin
      @(posedge clk); #1;
      dlat++;
    end
    chk("t6_lat", 32'(dlat), 32'd4);
    chk("t6_sum", 32'(sum16), 32'(SAT ? 16'h8000 : 16'h7FFF));
    chk("t6_carry", 32'(c16), 32'd1);
    chk("t6_ovf", 32'(v16), 32'd1);

    run1("n1a", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    @(posedge clk); #1;
    run1("n1b", 8'h80, 8'd1, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
